// File: rtl/cpu_pkg.sv
// Shared types and ISA constants for the CPU controller: FSM states,
// instruction classes, opcode/op encodings and datapath control codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_RD  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        IC_ILLEGAL = 3'd0,
        IC_MOVI    = 3'd1,
        IC_MOVR    = 3'd2,
        IC_ADD     = 3'd3,
        IC_CMP     = 3'd4,
        IC_AND     = 3'd5,
        IC_MVN     = 3'd6
    } iclass_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_PASS = 2'b00;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift
// fields, sign-extends imm8 and classifies the instruction.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [1:0]  o_sh,
    output logic [2:0]  o_rm,
    output logic [15:0] o_sximm8,
    output iclass_e     o_iclass,
    output logic        o_legal
);

    logic [2:0] w_opc;
    logic [1:0] w_op;

    assign w_opc    = i_ir[15:13];
    assign w_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = sext8(i_ir[7:0]);
    assign o_legal  = (o_iclass != IC_ILLEGAL);

    // Instruction classification from opcode and op fields
    always_comb begin
        o_iclass = IC_ILLEGAL;
        case (w_opc)
            OPC_MOV: begin
                case (w_op)
                    OP_MOVI: o_iclass = IC_MOVI;
                    OP_MOVR: o_iclass = IC_MOVR;
                    default: o_iclass = IC_ILLEGAL;
                endcase
            end
            OPC_ALU: begin
                case (w_op)
                    OP_ADD:  o_iclass = IC_ADD;
                    OP_CMP:  o_iclass = IC_CMP;
                    OP_AND:  o_iclass = IC_AND;
                    OP_MVN:  o_iclass = IC_MVN;
                    default: o_iclass = IC_ILLEGAL;
                endcase
            end
            default: o_iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and Moore control FSM sequencing the register-file/
// shifter/ALU datapath. Outputs are registered from the next state and IR.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [15:0] datapath_in,
    output logic        wb_sel,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic [2:0]  r_addr,
    output logic        en_A,
    output logic        en_B,
    output logic [1:0]  shift_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  ALU_op,
    output logic        en_C,
    output logic        en_status
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_ir;
    logic [15:0] w_ir_nxt;

    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    logic [15:0] w_sximm8;
    iclass_e     w_iclass;
    logic        w_legal;

    logic        r_w,         w_w_nxt;
    logic [15:0] r_dp_in,     w_dp_in_nxt;
    logic        r_wb_sel,    w_wb_sel_nxt;
    logic [2:0]  r_w_addr,    w_w_addr_nxt;
    logic        r_w_en,      w_w_en_nxt;
    logic [2:0]  r_r_addr,    w_r_addr_nxt;
    logic        r_en_a,      w_en_a_nxt;
    logic        r_en_b,      w_en_b_nxt;
    logic [1:0]  r_shift_op,  w_shift_op_nxt;
    logic        r_sel_a,     w_sel_a_nxt;
    logic [1:0]  r_alu_op,    w_alu_op_nxt;
    logic        r_en_c,      w_en_c_nxt;
    logic        r_en_status, w_en_status_nxt;

    // The IR only changes in WAIT, so decoding the next IR also decodes the
    // current one in every executing state.
    instr_decoder u_dec (
        .i_ir     (w_ir_nxt),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (w_sximm8),
        .o_iclass (w_iclass),
        .o_legal  (w_legal)
    );

    // Next IR value: captured only while idle
    always_comb begin
        w_ir_nxt = r_ir;
        if (reset) begin
            w_ir_nxt = 16'h0000;
        end else if (load && (r_state == S_WAIT)) begin
            w_ir_nxt = in;
        end else begin
            w_ir_nxt = r_ir;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (reset) begin
            w_state_nxt = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT:      w_state_nxt = s ? S_DECODE : S_WAIT;
                S_DECODE: begin
                    if (!w_legal) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        case (w_iclass)
                            IC_MOVI:                 w_state_nxt = S_WRITE_IMM;
                            IC_MOVR, IC_MVN:         w_state_nxt = S_GET_B;
                            IC_ADD, IC_CMP, IC_AND:  w_state_nxt = S_GET_A;
                            default:                 w_state_nxt = S_WAIT;
                        endcase
                    end
                end
                S_GET_A:     w_state_nxt = S_GET_B;
                S_GET_B:     w_state_nxt = S_ALU;
                S_ALU:       w_state_nxt = (w_iclass == IC_CMP) ? S_WAIT : S_WRITE_RD;
                S_WRITE_IMM: w_state_nxt = S_WAIT;
                S_WRITE_RD:  w_state_nxt = S_WAIT;
                default:     w_state_nxt = S_WAIT;
            endcase
        end
    end

    // Moore outputs for the state about to be entered
    always_comb begin
        w_w_nxt         = 1'b0;
        w_dp_in_nxt     = w_sximm8;
        w_wb_sel_nxt    = 1'b0;
        w_w_addr_nxt    = 3'b000;
        w_w_en_nxt      = 1'b0;
        w_r_addr_nxt    = 3'b000;
        w_en_a_nxt      = 1'b0;
        w_en_b_nxt      = 1'b0;
        w_shift_op_nxt  = SH_PASS;
        w_sel_a_nxt     = 1'b0;
        w_alu_op_nxt    = ALU_ADD;
        w_en_c_nxt      = 1'b0;
        w_en_status_nxt = 1'b0;
        case (w_state_nxt)
            S_WAIT: w_w_nxt = 1'b1;
            S_WRITE_IMM: begin
                w_w_addr_nxt = w_rn;
                w_wb_sel_nxt = 1'b1;
                w_w_en_nxt   = 1'b1;
            end
            S_GET_A: begin
                w_r_addr_nxt = w_rn;
                w_en_a_nxt   = 1'b1;
            end
            S_GET_B: begin
                w_r_addr_nxt = w_rm;
                w_en_b_nxt   = 1'b1;
            end
            S_ALU: begin
                w_shift_op_nxt = w_sh;
                case (w_iclass)
                    IC_MOVR: begin
                        w_sel_a_nxt = 1'b1;
                        w_en_c_nxt  = 1'b1;
                    end
                    IC_ADD: w_en_c_nxt = 1'b1;
                    IC_AND: begin
                        w_alu_op_nxt = ALU_AND;
                        w_en_c_nxt   = 1'b1;
                    end
                    IC_MVN: begin
                        w_alu_op_nxt = ALU_NOTB;
                        w_en_c_nxt   = 1'b1;
                    end
                    IC_CMP: begin
                        w_alu_op_nxt    = ALU_SUB;
                        w_en_status_nxt = 1'b1;
                    end
                    default: w_en_c_nxt = 1'b0;
                endcase
            end
            S_WRITE_RD: begin
                w_w_addr_nxt = w_rd;
                w_w_en_nxt   = 1'b1;
            end
            default: w_w_nxt = 1'b0;
        endcase
    end

    // State, IR and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT;
            r_ir        <= 16'h0000;
            r_w         <= 1'b1;
            r_dp_in     <= 16'h0000;
            r_wb_sel    <= 1'b0;
            r_w_addr    <= 3'b000;
            r_w_en      <= 1'b0;
            r_r_addr    <= 3'b000;
            r_en_a      <= 1'b0;
            r_en_b      <= 1'b0;
            r_shift_op  <= SH_PASS;
            r_sel_a     <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_en_c      <= 1'b0;
            r_en_status <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ir        <= w_ir_nxt;
            r_w         <= w_w_nxt;
            r_dp_in     <= w_dp_in_nxt;
            r_wb_sel    <= w_wb_sel_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_w_en      <= w_w_en_nxt;
            r_r_addr    <= w_r_addr_nxt;
            r_en_a      <= w_en_a_nxt;
            r_en_b      <= w_en_b_nxt;
            r_shift_op  <= w_shift_op_nxt;
            r_sel_a     <= w_sel_a_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_en_c      <= w_en_c_nxt;
            r_en_status <= w_en_status_nxt;
        end
    end

    assign w           = r_w;
    assign datapath_in = r_dp_in;
    assign wb_sel      = r_wb_sel;
    assign w_addr      = r_w_addr;
    assign w_en        = r_w_en;
    assign r_addr      = r_r_addr;
    assign en_A        = r_en_a;
    assign en_B        = r_en_b;
    assign shift_op    = r_shift_op;
    assign sel_A       = r_sel_a;
    assign sel_B       = 1'b0;
    assign ALU_op      = r_alu_op;
    assign en_C        = r_en_c;
    assign en_status   = r_en_status;

endmodule
